pdp8_trace_buffer: RTL

- Parametrised multi-channel capture buffer for debugging the PDP8e core; successor to the single-pattern logic-analyser RAM.
- Snoops instruction, major state and a data bus, e.g. AC.
- When the current instruction matches any of NCH programmable pattern/mask channels, it stores a tagged word once per entry into the capture state.
- Supports one-shot and circular modes, an arm/trigger sequencer, and a synchronous readback port for dumping from the bench or a front-panel path.

---
 rtl/trace_pkg.sv | 30 +++
 rtl/trace_ram.sv | 28 ++
 rtl/pdp8_trace_buffer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the PDP-8/e trace buffer: sequencer encodings,
// CPU major-state codes and a constant clog2 helper.
package trace_pkg;

   typedef enum logic [1:0] {
      TR_IDLE  = 2'd0,
      TR_ARMED = 2'd1,
      TR_RUN   = 2'd2,
      TR_DONE  = 2'd3
   } tr_state_t;

   // CPU major-state codes as produced by the core's state register
   localparam logic [4:0] ST_F1 = 5'd1;
   localparam logic [4:0] ST_F2 = 5'd2;
   localparam logic [4:0] ST_F3 = 5'd3;
   localparam logic [4:0] ST_D1 = 5'd4;
   localparam logic [4:0] ST_D2 = 5'd5;
   localparam logic [4:0] ST_D3 = 5'd6;
   localparam logic [4:0] ST_E1 = 5'd7;
   localparam logic [4:0] ST_E2 = 5'd8;
   localparam logic [4:0] ST_E3 = 5'd9;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read-during-write to the same address returns the previous contents.
module trace_ram #(
   parameter int WIDTH  = 14,
   parameter int ADDR_W = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Output register reset only; array contents survive reset
   always_ff @(posedge clk) begin
      if (reset) rdata <= '0;
      else       rdata <= mem[raddr];
   end

endmodule

// File: rtl/pdp8_trace_buffer.sv
// Multi-channel instruction trace buffer for the PDP-8/e core.
// Define TRACE_TIMESTAMP_EN to append a 16-bit inter-entry cycle delta.
module pdp8_trace_buffer
   import trace_pkg::*;
#(
   parameter int                 DATA_W    = 12,
   parameter int                 ADDR_W    = 13,
   parameter int                 NCH       = 4,
   parameter int                 STATE_W   = 5,
   parameter logic [STATE_W-1:0] CAP_STATE = STATE_W'(ST_F2),
   localparam int                CH_W      = (NCH > 1) ? clog2(NCH) : 1,
`ifdef TRACE_TIMESTAMP_EN
   localparam int                RD_W      = CH_W + DATA_W + 16
`else
   localparam int                RD_W      = CH_W + DATA_W
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_W-1:0]   din,
   input  logic [11:0]         instruction,
   input  logic [STATE_W-1:0]  state,
   input  logic [NCH*12-1:0]   pat,
   input  logic [NCH*12-1:0]   mask,
   input  logic [NCH-1:0]      ch_en,
   input  logic [CH_W-1:0]     trig_ch,
   input  logic                trig_en,
   input  logic                circular,
   input  logic                arm,
   input  logic                stop,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [RD_W-1:0]     rd_data,
   output logic [ADDR_W-1:0]   wr_ptr,
   output logic [ADDR_W:0]     count,
   output logic                wrapped,
   output logic                busy,
   output logic                done
);

   localparam int DEPTH = 1 << ADDR_W;

   tr_state_t          fsm, fsm_nxt;
   logic [STATE_W-1:0] prev_state;
   logic [NCH-1:0]     hit;
   logic [CH_W-1:0]    tag;
   logic               trig_hit, cap_evt, wr_en, full_nxt;
   logic [RD_W-1:0]    wdata;

   always_comb begin
      for (int i = 0; i < NCH; i++)
         hit[i] = ch_en[i] &&
                  (((instruction ^ pat[12*i +: 12]) & mask[12*i +: 12]) == 12'd0);
   end

   // Scan downward so the lowest matching channel ends up as the tag
   always_comb begin
      tag      = '0;
      trig_hit = 1'b0;
      for (int i = NCH-1; i >= 0; i--) begin
         if (hit[i]) tag = CH_W'(i);
         if (hit[i] && trig_ch == CH_W'(i)) trig_hit = 1'b1;
      end
   end

   // Edge-qualified on state entry: one event per instruction however long F2 is held
   assign cap_evt  = (state == CAP_STATE) && (prev_state != CAP_STATE) && (|hit);
   assign wr_en    = !reset && !arm && cap_evt &&
                     ((fsm == TR_RUN) || (fsm == TR_ARMED && (!trig_en || trig_hit)));
   assign full_nxt = (count >= (ADDR_W+1)'(DEPTH - 1));

   always_comb begin
      fsm_nxt = fsm;
      if (arm)
         fsm_nxt = TR_ARMED;
      else if (stop && (fsm == TR_ARMED || fsm == TR_RUN))
         fsm_nxt = TR_DONE;
      else if (wr_en && !circular && full_nxt)
         fsm_nxt = TR_DONE;
      else if (fsm == TR_ARMED && (!trig_en || wr_en))
         fsm_nxt = TR_RUN;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm        <= TR_IDLE;
         prev_state <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         wrapped    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         fsm        <= fsm_nxt;
         prev_state <= state;
         busy       <= (fsm_nxt == TR_ARMED) || (fsm_nxt == TR_RUN);
         done       <= (fsm_nxt == TR_DONE);
         if (arm) begin
            wr_ptr  <= '0;
            count   <= '0;
            wrapped <= 1'b0;
         end else if (wr_en) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (count != (ADDR_W+1)'(DEPTH)) count <= count + (ADDR_W+1)'(1);
            if (circular && wr_ptr == '1) wrapped <= 1'b1;
         end
      end
   end

`ifdef TRACE_TIMESTAMP_EN
   // Holds the cycle delta the next write would record (1 = written on the following cycle)
   logic [15:0] ts;

   always_ff @(posedge clk) begin
      if (reset || arm || wr_en) ts <= 16'd1;
      else if (ts != 16'hFFFF)   ts <= ts + 16'd1;
   end

   assign wdata = {tag, din, ts};
`else
   assign wdata = {tag, din};
`endif

   trace_ram #(
      .WIDTH  (RD_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (wdata),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule
